// File: rtl/memctl_pkg.sv
// Shared definitions for the memory-controller strobe blocks.
package memctl_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int GAP_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_HOLDOFF = 2'd2
  } estado_e;

endpackage

// File: rtl/impulso_a_pulso_if.sv
// Request/strobe bundle between a command source and the pulse stretcher.
interface impulso_a_pulso_if #(
  parameter int CNT_W = memctl_pkg::CNT_W_DEF
) ();

  logic             impulso;
  logic [CNT_W-1:0] longitud;
  logic             retrigger_en;
  logic             pulso;
  logic             ocupado;
  logic             terminado;
  logic             perdido;

  modport master (
    output impulso, longitud, retrigger_en,
    input  pulso, ocupado, terminado, perdido
  );

  modport slave (
    input  impulso, longitud, retrigger_en,
    output pulso, ocupado, terminado, perdido
  );

endinterface

// File: rtl/impulso_a_pulso_contador.sv
// Loadable down-counter that parks at zero; used for both pulse length and holdoff gap.
module contador_descendente
  import memctl_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         is_one_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load has priority; a decrement never wraps below zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign is_one_o = (count_q == W'(1));

endmodule

// File: rtl/impulso_a_pulso.sv
// One-shot pulse stretcher: impulse -> pulse of programmable length, then a fixed low gap.
module impulso_a_pulso
  import memctl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP   = 2
) (
  input  logic             clock,
  input  logic             reset,
  impulso_a_pulso_if.slave bus
);

  localparam logic [GAP_W-1:0] GAP_V = GAP_W'(GAP);

  estado_e          state_q;
  estado_e          state_d;
  logic             pend_q;
  logic             pend_d;
  logic             pulso_q;
  logic             pulso_d;
  logic             ocupado_q;
  logic             ocupado_d;
  logic             terminado_q;
  logic             terminado_d;
  logic             perdido_q;
  logic             perdido_d;

  logic             cnt_load_s;
  logic             cnt_en_s;
  logic [CNT_W-1:0] cnt_s;
  logic             cnt_is_one_s;
  logic             gap_load_s;
  logic             gap_en_s;
  logic [GAP_W-1:0] gap_s;
  logic             gap_is_one_s;

  logic             imp_s;
  logic             ret_s;
  logic [CNT_W-1:0] len_s;
  logic             len_nz_s;

  assign imp_s    = bus.impulso;
  assign ret_s    = bus.retrigger_en;
  assign len_s    = bus.longitud;
  assign len_nz_s = (len_s != '0);

  contador_descendente #(.W(CNT_W)) u_cnt (
    .clock      (clock),
    .reset      (reset),
    .load_i     (cnt_load_s),
    .load_val_i (len_s),
    .en_i       (cnt_en_s),
    .count_o    (cnt_s),
    .is_one_o   (cnt_is_one_s)
  );

  contador_descendente #(.W(GAP_W)) u_gap (
    .clock      (clock),
    .reset      (reset),
    .load_i     (gap_load_s),
    .load_val_i (GAP_V),
    .en_i       (gap_en_s),
    .count_o    (gap_s),
    .is_one_o   (gap_is_one_s)
  );

  // Next state, counter controls, one-deep queue and event flags.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    cnt_load_s  = 1'b0;
    cnt_en_s    = 1'b0;
    gap_load_s  = 1'b0;
    gap_en_s    = 1'b0;
    terminado_d = 1'b0;
    perdido_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (imp_s) begin
          if (len_nz_s) begin
            cnt_load_s = 1'b1;
            state_d    = ST_ACTIVE;
          end else begin
            perdido_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        cnt_en_s = (cnt_s != '0);
        if (imp_s && ret_s && len_nz_s) begin
          // Retrigger reload wins over the end-of-pulse transition.
          cnt_load_s = 1'b1;
        end else begin
          if (imp_s && ret_s) begin
            perdido_d = 1'b1;
          end else if (imp_s) begin
            if (pend_q) begin
              perdido_d = 1'b1;
            end else begin
              pend_d = 1'b1;
            end
          end else begin
            pend_d = pend_q;
          end
          if (cnt_is_one_s) begin
            state_d     = ST_HOLDOFF;
            gap_load_s  = 1'b1;
            terminado_d = 1'b1;
          end else begin
            state_d = ST_ACTIVE;
          end
        end
      end
      ST_HOLDOFF: begin
        gap_en_s = (gap_s != '0);
        if (gap_is_one_s) begin
          // An impulse arriving now merges with the queued request.
          if (pend_q || imp_s) begin
            pend_d = 1'b0;
            if (len_nz_s) begin
              cnt_load_s = 1'b1;
              state_d    = ST_ACTIVE;
            end else begin
              perdido_d = 1'b1;
              state_d   = ST_IDLE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end else if (imp_s) begin
          if (pend_q) begin
            perdido_d = 1'b1;
          end else begin
            pend_d = 1'b1;
          end
        end else begin
          state_d = ST_HOLDOFF;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pend_d  = 1'b0;
      end
    endcase
    pulso_d   = (state_d == ST_ACTIVE);
    ocupado_d = (state_d != ST_IDLE);
  end

  // State, queue and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      pulso_q     <= 1'b0;
      ocupado_q   <= 1'b0;
      terminado_q <= 1'b0;
      perdido_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pulso_q     <= pulso_d;
      ocupado_q   <= ocupado_d;
      terminado_q <= terminado_d;
      perdido_q   <= perdido_d;
    end
  end

  assign bus.pulso     = pulso_q;
  assign bus.ocupado   = ocupado_q;
  assign bus.terminado = terminado_q;
  assign bus.perdido   = perdido_q;

endmodule

// File: tb/tb_impulso_a_pulso.sv
// Directed bench for impulso_a_pulso (CNT_W=8, GAP=2); bit i of a trace is the output after edge i.
module tb_impulso_a_pulso;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  impulso_a_pulso_if #(.CNT_W(8)) bus ();

  impulso_a_pulso #(.CNT_W(8), .GAP(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic run_trace(input logic [31:0] imp_pat, input logic [7:0] len, input logic ret,
                           input int n, output logic [31:0] o_p, output logic [31:0] o_o,
                           output logic [31:0] o_t, output logic [31:0] o_l);
    o_p = 32'h0; o_o = 32'h0; o_t = 32'h0; o_l = 32'h0;
    bus.longitud     = len;
    bus.retrigger_en = ret;
    for (int i = 0; i < n; i++) begin
      bus.impulso = imp_pat[i];
      tick();
      o_p[i] = bus.pulso;
      o_o[i] = bus.ocupado;
      o_t[i] = bus.terminado;
      o_l[i] = bus.perdido;
    end
    bus.impulso = 1'b0;
  endtask

  task automatic test_reset();
    bus.impulso = 1'b0; bus.longitud = 8'd0; bus.retrigger_en = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.pulso, bus.ocupado, bus.terminado, bus.perdido} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 0000",
               {bus.pulso, bus.ocupado, bus.terminado, bus.perdido});
    end
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if ({bus.pulso, bus.ocupado} !== 2'b00) begin
      failures++;
      $display("FAIL reset_idle: got %b expected 00", {bus.pulso, bus.ocupado});
    end
  endtask

  task automatic test_basic();
    logic [31:0] p, o, t, l;
    run_trace(32'h1, 8'd4, 1'b0, 10, p, o, t, l);
    checks++; if (p !== 32'h0000000F) begin failures++; $display("FAIL basic_pulso: got %h expected 0000000f", p); end
    checks++; if (o !== 32'h0000003F) begin failures++; $display("FAIL basic_ocupado: got %h expected 0000003f", o); end
    checks++; if (t !== 32'h00000010) begin failures++; $display("FAIL basic_terminado: got %h expected 00000010", t); end
    checks++; if (l !== 32'h00000000) begin failures++; $display("FAIL basic_perdido: got %h expected 00000000", l); end
  endtask

  // Second impulse sampled at the end of the second high cycle: 2 + 4 high cycles.
  task automatic test_retrigger();
    logic [31:0] p, o, t, l;
    run_trace(32'h5, 8'd4, 1'b1, 10, p, o, t, l);
    checks++; if (p !== 32'h0000003F) begin failures++; $display("FAIL retrig_pulso: got %h expected 0000003f", p); end
    checks++; if (o !== 32'h000000FF) begin failures++; $display("FAIL retrig_ocupado: got %h expected 000000ff", o); end
    checks++; if (t !== 32'h00000040) begin failures++; $display("FAIL retrig_terminado: got %h expected 00000040", t); end
    checks++; if (l !== 32'h00000000) begin failures++; $display("FAIL retrig_perdido: got %h expected 00000000", l); end
  endtask

  task automatic test_queue();
    logic [31:0] p, o, t, l;
    run_trace(32'hD, 8'd3, 1'b0, 12, p, o, t, l);
    checks++; if (p !== 32'h000000E7) begin failures++; $display("FAIL queue_pulso: got %h expected 000000e7", p); end
    checks++; if (o !== 32'h000003FF) begin failures++; $display("FAIL queue_ocupado: got %h expected 000003ff", o); end
    checks++; if (t !== 32'h00000108) begin failures++; $display("FAIL queue_terminado: got %h expected 00000108", t); end
    checks++; if (l !== 32'h00000008) begin failures++; $display("FAIL queue_perdido: got %h expected 00000008", l); end
  endtask

  task automatic test_zero_len();
    logic [31:0] p, o, t, l;
    run_trace(32'h1, 8'd0, 1'b0, 4, p, o, t, l);
    checks++; if (p !== 32'h00000000) begin failures++; $display("FAIL zero_pulso: got %h expected 00000000", p); end
    checks++; if (o !== 32'h00000000) begin failures++; $display("FAIL zero_ocupado: got %h expected 00000000", o); end
    checks++; if (t !== 32'h00000000) begin failures++; $display("FAIL zero_terminado: got %h expected 00000000", t); end
    checks++; if (l !== 32'h00000001) begin failures++; $display("FAIL zero_perdido: got %h expected 00000001", l); end
  endtask

  // Impulse queued in holdoff (retrigger mode), plus one merged on the consuming cycle.
  task automatic test_holdoff_queue();
    logic [31:0] p, o, t, l;
    run_trace(32'h19, 8'd2, 1'b1, 10, p, o, t, l);
    checks++; if (p !== 32'h00000033) begin failures++; $display("FAIL holdq_pulso: got %h expected 00000033", p); end
    checks++; if (o !== 32'h000000FF) begin failures++; $display("FAIL holdq_ocupado: got %h expected 000000ff", o); end
    checks++; if (t !== 32'h00000044) begin failures++; $display("FAIL holdq_terminado: got %h expected 00000044", t); end
    checks++; if (l !== 32'h00000000) begin failures++; $display("FAIL holdq_perdido: got %h expected 00000000", l); end
  endtask

  // Length 1 pulses, second impulse lands exactly on the last gap cycle.
  task automatic test_gap_edge();
    logic [31:0] p, o, t, l;
    run_trace(32'h9, 8'd1, 1'b0, 8, p, o, t, l);
    checks++; if (p !== 32'h00000009) begin failures++; $display("FAIL gapedge_pulso: got %h expected 00000009", p); end
    checks++; if (o !== 32'h0000003F) begin failures++; $display("FAIL gapedge_ocupado: got %h expected 0000003f", o); end
    checks++; if (t !== 32'h00000012) begin failures++; $display("FAIL gapedge_terminado: got %h expected 00000012", t); end
    checks++; if (l !== 32'h00000000) begin failures++; $display("FAIL gapedge_perdido: got %h expected 00000000", l); end
  endtask

  task automatic test_reset_mid_pulse();
    int highs;
    bus.longitud = 8'd10; bus.retrigger_en = 1'b0;
    bus.impulso = 1'b1;
    tick();
    bus.impulso = 1'b1;
    tick();
    bus.impulso = 1'b0;
    checks++;
    if (bus.pulso !== 1'b1) begin failures++; $display("FAIL rst_mid_before: pulso got %b expected 1", bus.pulso); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({bus.pulso, bus.ocupado} !== 2'b00) begin
      failures++; $display("FAIL rst_mid_after: got %b expected 00", {bus.pulso, bus.ocupado});
    end
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.pulso === 1'b1 || bus.ocupado === 1'b1) highs++;
    end
    checks++;
    if (highs !== 0) begin failures++; $display("FAIL rst_mid_no_pending: busy cycles got %0d expected 0", highs); end
  endtask

  task automatic test_long();
    int n;
    int highs;
    bus.longitud = 8'd255; bus.retrigger_en = 1'b0;
    bus.impulso = 1'b1;
    tick();
    bus.impulso = 1'b0;
    n = 0;
    while (bus.pulso === 1'b1 && n < 400) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 255) begin failures++; $display("FAIL long_length: high cycles got %0d expected 255", n); end
    checks++;
    if (bus.terminado !== 1'b1) begin failures++; $display("FAIL long_terminado: got %b expected 1", bus.terminado); end
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.pulso === 1'b1) highs++;
    end
    checks++;
    if (highs !== 0) begin failures++; $display("FAIL long_no_wrap: extra high cycles got %0d expected 0", highs); end
    checks++;
    if (bus.ocupado !== 1'b0) begin failures++; $display("FAIL long_idle: ocupado got %b expected 0", bus.ocupado); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.impulso = 1'b0; bus.longitud = 8'd0; bus.retrigger_en = 1'b0;
    test_reset();
    test_basic();
    test_retrigger();
    test_queue();
    test_zero_len();
    test_holdoff_queue();
    test_gap_edge();
    test_reset_mid_pulse();
    test_long();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
